countdown_timer: RTL and testbench

//  Loadable mm:ss BCD countdown timer: counts down from a preset value to 00:00 at 1 Hz.

---
 rtl/countdown_timer_pkg.sv | 19 +
 rtl/countdown_timer_sec_tick_gen.sv | 33 +++
 rtl/countdown_timer.sv | 120 ++++++++++++
 tb/tb_countdown_timer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the mm:ss BCD countdown timer.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  // Saturate a preset digit to its legal BCD ceiling.
  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/countdown_timer_sec_tick_gen.sv
// One-second prescaler: counts while enabled, holds otherwise, clear wins.
module sec_tick_gen #(
  parameter int unsigned TICKS_PER_SEC = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick_c
);

  localparam int unsigned CNT_W = $clog2(TICKS_PER_SEC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign tick_c = enable & ~clear & (cnt_q == CNT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable mm:ss BCD countdown timer with 1 Hz decrement and single-cycle expiry pulse.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] ld_mt,
  input  logic [3:0] ld_mo,
  input  logic [3:0] ld_st,
  input  logic [3:0] ld_so,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] mt,
  output logic [3:0] mo,
  output logic [3:0] st,
  output logic [3:0] so,
  output logic       running,
  output logic       done,
  output logic       expired
);

  state_e     state_q, state_d;
  logic [3:0] mt_q, mt_d, mo_q, mo_d, st_q, st_d, so_q, so_d;
  logic       running_q, running_d, done_q, done_d, expired_q, expired_d;
  logic       tick_c, presc_clear_c, presc_en_c;
  logic       nonzero_c, at_one_c;
  logic       borrow_so_c, borrow_st_c, borrow_mo_c;

  // Prescaler sits at zero outside RUN/PAUSED so the first tick lands TICKS_PER_SEC edges after start.
  assign presc_clear_c = load | (state_q == ST_IDLE);
  assign presc_en_c    = (state_q == ST_RUN) & ~pause & ~load;

  sec_tick_gen #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_tick (
    .clock  (clock),
    .reset  (reset),
    .clear  (presc_clear_c),
    .enable (presc_en_c),
    .tick_c (tick_c)
  );

  assign nonzero_c   = (mt_q != 4'd0) | (mo_q != 4'd0) | (st_q != 4'd0) | (so_q != 4'd0);
  assign at_one_c    = (mt_q == 4'd0) & (mo_q == 4'd0) & (st_q == 4'd0) & (so_q == 4'd1);
  assign borrow_so_c = (so_q == 4'd0);
  assign borrow_st_c = borrow_so_c & (st_q == 4'd0);
  assign borrow_mo_c = borrow_st_c & (mo_q == 4'd0);

  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    mo_d    = mo_q;
    st_d    = st_q;
    so_d    = so_q;
    if (load) begin
      mt_d    = clamp_digit(ld_mt, BCD_MAX);
      mo_d    = clamp_digit(ld_mo, BCD_MAX);
      st_d    = clamp_digit(ld_st, SEC_TENS_MAX);
      so_d    = clamp_digit(ld_so, BCD_MAX);
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && !pause && nonzero_c) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else if (tick_c) begin
            so_d = borrow_so_c ? BCD_MAX : so_q - 4'd1;
            if (borrow_so_c) st_d = (st_q == 4'd0) ? SEC_TENS_MAX : st_q - 4'd1;
            if (borrow_st_c) mo_d = (mo_q == 4'd0) ? BCD_MAX : mo_q - 4'd1;
            if (borrow_mo_c) mt_d = mt_q - 4'd1;
            if (at_one_c) state_d = ST_DONE;
          end
        end
        ST_PAUSED: begin
          if (start && !pause) state_d = ST_RUN;
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
    expired_d = (state_q == ST_RUN) && (state_d == ST_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mt_q      <= '0;
      mo_q      <= '0;
      st_q      <= '0;
      so_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mt_q      <= mt_d;
      mo_q      <= mo_d;
      st_q      <= st_d;
      so_q      <= so_d;
      running_q <= running_d;
      done_q    <= done_d;
      expired_q <= expired_d;
    end
  end

  assign mt      = mt_q;
  assign mo      = mo_q;
  assign st      = st_q;
  assign so      = so_q;
  assign running = running_q;
  assign done    = done_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with a 4-cycle second.
module tb_countdown_timer;

  logic       clock, reset, load, start, pause;
  logic [3:0] ld_mt, ld_mo, ld_st, ld_so;
  logic [3:0] mt, mo, st, so;
  logic       running, done, expired;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [7:0]  n;
    logic        ld;
    logic [15:0] ldv;
    logic        st;
    logic        pa;
    logic [15:0] ev;
    logic        er;
    logic        ed;
    logic        ee;
  } vec_t;

  vec_t tbl[$];

  countdown_timer #(.TICKS_PER_SEC(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .ld_mt   (ld_mt),
    .ld_mo   (ld_mo),
    .ld_st   (ld_st),
    .ld_so   (ld_so),
    .start   (start),
    .pause   (pause),
    .mt      (mt),
    .mo      (mo),
    .st      (st),
    .so      (so),
    .running (running),
    .done    (done),
    .expired (expired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic l, input logic [15:0] v, input logic s, input logic p);
    load = l;
    {ld_mt, ld_mo, ld_st, ld_so} = v;
    start = s;
    pause = p;
  endtask

  task automatic check(input string nm, input logic [15:0] ev, input logic er,
                       input logic ed, input logic ee);
    logic [18:0] got, want;
    got  = {mt, mo, st, so, running, done, expired};
    want = {ev, er, ed, ee};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h%h:%h%h run=%b done=%b expired=%b, want %h:%h run=%b done=%b expired=%b",
               nm, mt, mo, st, so, running, done, expired, ev[15:8], ev[7:0], er, ed, ee);
    end
  endtask

  function automatic void add(input int n, input logic l, input logic [15:0] v, input logic s,
                              input logic p, input logic [15:0] ev, input logic er,
                              input logic ed, input logic ee);
    vec_t t;
    t = '{n: 8'(n), ld: l, ldv: v, st: s, pa: p, ev: ev, er: er, ed: ed, ee: ee};
    tbl.push_back(t);
  endfunction

  initial begin
    reset = 1'b1;
    drive(1'b0, 16'h0000, 1'b0, 1'b0);

    // Count 00:03 to expiry, then DONE holds and ignores start/pause.
    add(1, 1, 16'h0003, 0, 0, 16'h0003, 0, 0, 0);
    add(1, 0, 16'h0000, 1, 0, 16'h0003, 1, 0, 0);
    add(3, 0, 16'h0000, 0, 0, 16'h0003, 1, 0, 0);
    add(1, 0, 16'h0000, 0, 0, 16'h0002, 1, 0, 0);
    add(4, 0, 16'h0000, 0, 0, 16'h0001, 1, 0, 0);
    add(3, 0, 16'h0000, 0, 0, 16'h0001, 1, 0, 0);
    add(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 1);
    add(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0);
    add(5, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0);
    add(2, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 0);
    add(2, 0, 16'h0000, 1, 1, 16'h0000, 0, 1, 0);
    add(1, 1, 16'h0002, 0, 0, 16'h0002, 0, 0, 0);
    add(1, 0, 16'h0000, 1, 0, 16'h0002, 1, 0, 0);
    add(4, 0, 16'h0000, 0, 0, 16'h0001, 1, 0, 0);
    add(4, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 1);
    // Borrow chains.
    add(1, 1, 16'h0100, 0, 0, 16'h0100, 0, 0, 0);
    add(1, 0, 16'h0000, 1, 0, 16'h0100, 1, 0, 0);
    add(4, 0, 16'h0000, 0, 0, 16'h0059, 1, 0, 0);
    add(1, 1, 16'h1000, 0, 0, 16'h1000, 0, 0, 0);
    add(1, 0, 16'h0000, 1, 0, 16'h1000, 1, 0, 0);
    add(4, 0, 16'h0000, 0, 0, 16'h0959, 1, 0, 0);
    // Clamping, zero start and start masked by pause.
    add(1, 1, 16'h007C, 0, 0, 16'h0059, 0, 0, 0);
    add(1, 1, 16'hCA6F, 0, 0, 16'h9959, 0, 0, 0);
    add(1, 1, 16'h0000, 0, 0, 16'h0000, 0, 0, 0);
    add(1, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0);
    add(3, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0);
    add(1, 1, 16'h0003, 0, 0, 16'h0003, 0, 0, 0);
    add(2, 0, 16'h0000, 1, 1, 16'h0003, 0, 0, 0);

    cyc(2);
    check("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    cyc(1);
    check("post_reset", 16'h0000, 1'b0, 1'b0, 1'b0);

    foreach (tbl[i]) begin
      drive(tbl[i].ld, tbl[i].ldv, tbl[i].st, tbl[i].pa);
      cyc(int'(tbl[i].n));
      check($sformatf("vec%0d", i), tbl[i].ev, tbl[i].er, tbl[i].ed, tbl[i].ee);
    end

    // Pause mid-second holds the prescaler; pause on the tick edge keeps the tick.
    drive(1'b1, 16'h0005, 1'b0, 1'b0); cyc(1);
    drive(1'b0, 16'h0000, 1'b1, 1'b0); cyc(1);
    start = 1'b0; cyc(4);
    check("pause_first_dec", 16'h0004, 1'b1, 1'b0, 1'b0);
    cyc(2);
    pause = 1'b1; cyc(1);
    check("pause_enter", 16'h0004, 1'b0, 1'b0, 1'b0);
    cyc(19);
    check("pause_hold", 16'h0004, 1'b0, 1'b0, 1'b0);
    pause = 1'b0; start = 1'b1; cyc(1);
    check("resume", 16'h0004, 1'b1, 1'b0, 1'b0);
    start = 1'b0; cyc(1);
    check("resume_r1", 16'h0004, 1'b1, 1'b0, 1'b0);
    cyc(1);
    check("resume_r2_dec", 16'h0003, 1'b1, 1'b0, 1'b0);
    cyc(3);
    check("pre_tick", 16'h0003, 1'b1, 1'b0, 1'b0);
    pause = 1'b1; cyc(1);
    check("pause_on_tick", 16'h0003, 1'b0, 1'b0, 1'b0);
    pause = 1'b0; start = 1'b1; cyc(1);
    check("resume_held_tick", 16'h0003, 1'b1, 1'b0, 1'b0);
    start = 1'b0; cyc(1);
    check("held_tick_fires", 16'h0002, 1'b1, 1'b0, 1'b0);

    // Load on the tick edge wins with no decrement; async reset mid-run.
    drive(1'b1, 16'h0010, 1'b0, 1'b0); cyc(1);
    drive(1'b0, 16'h0000, 1'b1, 1'b0); cyc(1);
    start = 1'b0; cyc(3);
    check("pre_load_tick", 16'h0010, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 16'h0030, 1'b0, 1'b0); cyc(1);
    check("load_on_tick", 16'h0030, 1'b0, 1'b0, 1'b0);
    load = 1'b0; cyc(4);
    check("load_no_dec", 16'h0030, 1'b0, 1'b0, 1'b0);
    start = 1'b1; cyc(1);
    start = 1'b0; cyc(5);
    check("run_0029", 16'h0029, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1 check("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    cyc(1);
    check("reset_held", 16'h0000, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
